// File: rtl/fxp_ln_pipe_if.sv
// Stream bundle for the pipelined natural-log unit: operand in, result out,
// each direction with its own valid/ready pair.
interface fxp_ln_pipe_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  inp;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] outp;
   logic             err;

   modport master (
      output in_valid, inp, out_ready,
      input  in_ready, out_valid, outp, err
   );

   modport slave (
      input  in_valid, inp, out_ready,
      output in_ready, out_valid, outp, err
   );
endinterface

// File: rtl/fxp_ln_pipe.sv
// Fully pipelined fixed-point ln(x): x = 2^k*(1+f), ln(x) = k*LN2 + P(f),
// where P is a degree-5 Horner polynomial in Q.16.
module fxp_ln_pipe #(
   parameter int INT_WIDTH      = 4,
   parameter int FRAC_WIDTH     = 4,
   parameter int OUT_INT_WIDTH  = 4,
   parameter int OUT_FRAC_WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   fxp_ln_pipe_if.slave  bus
);

   localparam int IW = INT_WIDTH + FRAC_WIDTH;
   localparam int OW = OUT_INT_WIDTH + OUT_FRAC_WIDTH;
   localparam int SH = 16 - OUT_FRAC_WIDTH;
   localparam int SW = 40;

   localparam logic signed [17:0] C5 = 18'sd1954;
   localparam logic signed [17:0] C4 = -18'sd8517;
   localparam logic signed [17:0] C3 = 18'sd18601;
   localparam logic signed [17:0] C2 = -18'sd32093;
   localparam logic signed [17:0] C1 = 18'sd65481;

   localparam logic signed [SW-1:0] LN2  = 40'sd45426;
   localparam logic signed [SW-1:0] RND  = (40'sd1 <<< SH) >>> 1;
   localparam logic signed [SW-1:0] OMAX = (40'sd1 <<< (OW - 1)) - 40'sd1;
   localparam logic signed [SW-1:0] OMIN = -(40'sd1 <<< (OW - 1));

   // One Horner step: c + (t*f >> 16), with f treated as non-negative Q0.16.
   function automatic logic signed [17:0] hornerStep(
      input logic signed [17:0] t,
      input logic        [15:0] f,
      input logic signed [17:0] c
   );
      logic signed [34:0] prod;
      prod = 35'(t) * 35'($signed({1'b0, f}));
      return 18'(35'(c) + (prod >>> 16));
   endfunction

   logic                 w_adv;
   logic [7:0]           r_v;
   logic                 r_outValid;
   logic [OW-1:0]        r_outp;
   logic                 r_outErr;

   logic [IW-1:0]        r_x0;
   logic [15:0]          r_f   [1:5];
   logic signed [15:0]   r_k   [1:6];
   logic                 r_err [1:7];
   logic signed [17:0]   r_t   [2:5];
   logic signed [17:0]   r_y6;
   logic signed [SW-1:0] r_s7;

   logic [15:0]          w_p;
   logic [15:0]          w_f;
   logic signed [15:0]   w_k;
   logic                 w_zero;
   logic signed [17:0]   w_t2;
   logic signed [17:0]   w_t3;
   logic signed [17:0]   w_t4;
   logic signed [17:0]   w_t5;
   logic signed [17:0]   w_y6;
   logic signed [SW-1:0] w_s7;
   logic signed [SW-1:0] w_rnd;
   logic signed [SW-1:0] w_sat;

   assign w_adv        = !r_outValid || bus.out_ready;
   assign bus.in_ready = w_adv;
   assign bus.out_valid = r_outValid;
   assign bus.outp     = r_outp;
   assign bus.err      = r_outErr;

   // Leading-one detect; the shift leaves the MSB at bit 16 so f is the bits below it.
   always_comb begin
      w_p = '0;
      for (int i = 0; i < IW; i++) begin
         if (r_x0[i]) begin
            w_p = 16'(i);
         end
      end
      w_f    = 16'({r_x0, 16'b0} >> w_p);
      w_k    = $signed(w_p) - $signed(16'(FRAC_WIDTH));
      w_zero = (r_x0 == '0);
   end

   always_comb begin
      w_t2 = hornerStep(C5, r_f[1], C4);
      w_t3 = hornerStep(r_t[2], r_f[2], C3);
      w_t4 = hornerStep(r_t[3], r_f[3], C2);
      w_t5 = hornerStep(r_t[4], r_f[4], C1);
      w_y6 = hornerStep(r_t[5], r_f[5], 18'sd0);
      w_s7 = (40'(r_k[6]) * LN2) + 40'(r_y6);
   end

   // Round half up to the output fraction width, then clamp to the output range.
   always_comb begin
      w_rnd = (r_s7 + RND) >>> SH;
      if (r_err[7]) begin
         w_sat = OMIN;
      end else if (w_rnd > OMAX) begin
         w_sat = OMAX;
      end else if (w_rnd < OMIN) begin
         w_sat = OMIN;
      end else begin
         w_sat = w_rnd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v        <= '0;
         r_outValid <= 1'b0;
         r_outp     <= '0;
         r_outErr   <= 1'b0;
      end else if (w_adv) begin
         r_v        <= {r_v[6:0], bus.in_valid};
         r_outValid <= r_v[7];
         r_outp     <= OW'(w_sat);
         r_outErr   <= r_err[7];
      end
   end

   // Datapath registers need no reset: the valid chain alone decides what is real.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_x0     <= bus.inp;
         r_f[1]   <= w_f;
         r_k[1]   <= w_k;
         r_err[1] <= w_zero;
         for (int s = 2; s <= 5; s++) begin
            r_f[s] <= r_f[s-1];
         end
         for (int s = 2; s <= 6; s++) begin
            r_k[s] <= r_k[s-1];
         end
         for (int s = 2; s <= 7; s++) begin
            r_err[s] <= r_err[s-1];
         end
         r_t[2] <= w_t2;
         r_t[3] <= w_t3;
         r_t[4] <= w_t4;
         r_t[5] <= w_t5;
         r_y6   <= w_y6;
         r_s7   <= w_s7;
      end
   end

endmodule

// File: tb/tb_fxp_ln_pipe.sv
// Directed bench for fxp_ln_pipe: hand-computed ln values in Q4.16, flow control,
// stall and mid-flight reset behaviour.
module tb_fxp_ln_pipe;

   localparam int IW = 8;
   localparam int OW = 20;

   typedef struct {
      int val;
      bit err;
   } expT;

   logic clk = 1'b0;
   logic rst;

   int assertCount = 0;
   int failCount   = 0;
   int resultCount = 0;
   int spurious    = 0;
   int cycleNo     = 0;
   int firstRes    = -1;
   int lastRes     = -1;
   expT expQ[$];

   always #5 clk = ~clk;

   fxp_ln_pipe_if #(.IN_W(IW), .OUT_W(OW)) bus();

   fxp_ln_pipe #(
      .INT_WIDTH(4),
      .FRAC_WIDTH(4),
      .OUT_INT_WIDTH(4),
      .OUT_FRAC_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Q4.16 results, Horner evaluated by hand with floor shifts:
   // y(.125)=7717 y(.25)=14623 y(.375)=20869 y(.5)=26571 y(.625)=31816
   // y(.75)=36674 y(.875)=41194 y(0.9921875)=45167, result = k*45426 + y.
   function automatic expT expectFor(input logic [7:0] x);
      expT e;
      e.err = 1'b0;
      case (x)
         8'h00: begin e.val = -524288; e.err = 1'b1; end
         8'h01: e.val = -181704;
         8'h02: e.val = -136278;
         8'h03: e.val = -109707;
         8'h04: e.val = -90852;
         8'h05: e.val = -76229;
         8'h06: e.val = -64281;
         8'h07: e.val = -54178;
         8'h08: e.val = -45426;
         8'h09: e.val = -37709;
         8'h0A: e.val = -30803;
         8'h0B: e.val = -24557;
         8'h0C: e.val = -18855;
         8'h0D: e.val = -13610;
         8'h0E: e.val = -8752;
         8'h0F: e.val = -4232;
         8'h10: e.val = 0;
         8'h18: e.val = 26571;
         8'h20: e.val = 45426;
         8'hFF: e.val = 181445;
         default: e.val = 2147483647;
      endcase
      return e;
   endfunction

   function automatic int outVal();
      return int'($signed(bus.outp));
   endfunction

   // Called at a falling edge; drives one cycle, scores any result handshake, advances.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy,
                                output logic accepted);
      expT e;
      bus.in_valid  = v;
      bus.inp       = d;
      bus.out_ready = rdy;
      #1;
      if (bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            spurious++;
            checkOutput("spurious_out_valid", int'(bus.out_valid), 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("result_value", outVal(), e.val);
            checkOutput("result_err", int'(bus.err), int'(e.err));
            resultCount++;
            if (firstRes < 0) firstRes = cycleNo;
            lastRes = cycleNo;
         end
      end
      accepted = v && bus.in_ready;
      if (accepted) expQ.push_back(expectFor(d));
      @(posedge clk);
      cycleNo++;
      @(negedge clk);
   endtask

   task automatic pushOp(input logic [7:0] d);
      logic acc;
      int   tries;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 50) begin
         applyStimulus(1'b1, d, 1'b1, acc);
         tries++;
      end
      checkOutput("operand_accepted", int'(acc), 1);
   endtask

   task automatic drain(input int budget);
      logic acc;
      int   n;
      n = 0;
      while (expQ.size() > 0 && n < budget) begin
         applyStimulus(1'b0, 8'h00, 1'b1, acc);
         n++;
      end
      checkOutput("drain_empty", expQ.size(), 0);
   endtask

   task automatic stallCycle(input logic [7:0] d);
      logic acc;
      bus.in_valid  = 1'b1;
      bus.inp       = d;
      bus.out_ready = 1'b0;
      #1;
      checkOutput("stall_in_ready", int'(bus.in_ready), 0);
      checkOutput("stall_out_valid", int'(bus.out_valid), 1);
      if (expQ.size() > 0) begin
         checkOutput("stall_outp", outVal(), expQ[0].val);
         checkOutput("stall_err", int'(bus.err), int'(expQ[0].err));
      end
      applyStimulus(1'b1, d, 1'b0, acc);
      checkOutput("stall_no_accept", int'(acc), 0);
   endtask

   logic [7:0] singles [6] = '{8'h20, 8'h08, 8'hFF, 8'h01, 8'h18, 8'h00};
   logic [7:0] stallOps[9] = '{8'h18, 8'hFF, 8'h20, 8'h08, 8'h00, 8'h03, 8'h06, 8'h0C, 8'h0F};
   logic [7:0] flushOps[4] = '{8'h02, 8'h04, 8'h05, 8'h07};

   initial begin
      logic acc;
      int   lat;
      int   r0;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.inp       = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", int'(bus.out_valid), 0);
      checkOutput("reset_outp", outVal(), 0);
      checkOutput("reset_err", int'(bus.err), 0);
      rst = 1'b0;

      $display("[TB] latency check with x=1.0");
      bus.in_valid  = 1'b1;
      bus.inp       = 8'h10;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("idle_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("latency", lat, 8);
      checkOutput("ln_1_outp", outVal(), 0);
      checkOutput("ln_1_err", int'(bus.err), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("drained_out_valid", int'(bus.out_valid), 0);

      $display("[TB] single operands");
      foreach (singles[i]) begin
         pushOp(singles[i]);
         drain(30);
      end

      $display("[TB] back-to-back stream 0x01..0x10");
      r0       = resultCount;
      firstRes = -1;
      for (int x = 1; x <= 16; x++) begin
         applyStimulus(1'b1, 8'(x), 1'b1, acc);
         checkOutput("stream_in_ready", int'(acc), 1);
      end
      drain(40);
      checkOutput("stream_count", resultCount - r0, 16);
      checkOutput("stream_back_to_back", lastRes - firstRes, 15);

      $display("[TB] stall with out_ready low for 5 cycles");
      r0 = resultCount;
      foreach (stallOps[i]) begin
         applyStimulus(1'b1, stallOps[i], 1'b1, acc);
         checkOutput("prestall_accept", int'(acc), 1);
      end
      for (int c = 0; c < 5; c++) stallCycle(8'h0E);
      pushOp(8'h0E);
      drain(40);
      checkOutput("stall_count", resultCount - r0, 10);

      $display("[TB] reset with operands in flight");
      foreach (flushOps[i]) applyStimulus(1'b1, flushOps[i], 1'b1, acc);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("flush_out_valid", int'(bus.out_valid), 0);
      checkOutput("flush_outp", outVal(), 0);
      expQ.delete();
      spurious = 0;
      for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
      checkOutput("flush_no_stale", spurious, 0);
      pushOp(8'h20);
      drain(30);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
